// File: rtl/uart_vec_assembler_if.sv
// Bundles the byte-in / vector-out signals of the UART-to-sorter framer.
// The slave modport faces the assembler; the master modport faces its environment.
interface uart_vec_assembler_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [WIDTH*DEPTH-1:0] vec_data;
  logic                   vec_valid;
  logic                   vec_ready;
  logic                   overflow;
  logic                   timeout_err;
  logic [15:0]            frame_count;

  modport master (
    output rx_data, rx_valid, vec_ready,
    input  vec_data, vec_valid, overflow, timeout_err, frame_count
  );

  modport slave (
    input  rx_data, rx_valid, vec_ready,
    output vec_data, vec_valid, overflow, timeout_err, frame_count
  );
endinterface

// File: rtl/uart_vec_assembler.sv
// Packs a UART byte stream into WIDTH-bit words, groups DEPTH words into one vector
// and offers it to the sort core over valid/ready, with timeout and overflow reporting.
module uart_vec_assembler #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int BIG_ENDIAN     = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 rst,
  uart_vec_assembler_if.slave bus
);
  localparam int BYTES  = WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFF_W  = $clog2(WIDTH * DEPTH) + 1;

  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(BYTES - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(DEPTH - 1);
  localparam logic [31:0]       IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]             r_state;
  logic [WIDTH*DEPTH-1:0] r_vec_data;
  logic                   r_vec_valid;
  logic                   r_overflow;
  logic                   r_timeout_err;
  logic [15:0]            r_frame_count;
  logic [BIDX_W-1:0]      r_byte_idx;
  logic [WIDX_W-1:0]      r_word_idx;
  logic [31:0]            r_idle_cnt;

  logic [BIDX_W-1:0]      w_lane;
  logic [OFF_W-1:0]       w_off;
  logic                   w_partial;

  // Bit offset of the byte lane the next received byte lands in.
  always_comb begin
    w_lane    = (BIG_ENDIAN != 0) ? (LAST_BYTE - r_byte_idx) : r_byte_idx;
    w_off     = OFF_W'(r_word_idx) * OFF_W'(WIDTH) + OFF_W'(w_lane) * OFF_W'(8);
    w_partial = (r_byte_idx != '0) || (r_word_idx != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= COLLECT;
      r_vec_data    <= '0;
      r_vec_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
      r_byte_idx    <= '0;
      r_word_idx    <= '0;
      r_idle_cnt    <= '0;
    end else begin
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (bus.rx_valid) begin
            r_vec_data[w_off +: 8] <= bus.rx_data;
            r_idle_cnt             <= '0;
            if (r_byte_idx == LAST_BYTE) begin
              r_byte_idx <= '0;
              if (r_word_idx == LAST_WORD) begin
                r_word_idx  <= '0;
                r_state     <= HOLD;
                r_vec_valid <= 1'b1;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          // Stale partial frames are dropped; the vector is never flagged valid.
          end else if ((TIMEOUT_CYCLES > 0) && w_partial) begin
            if (r_idle_cnt == IDLE_LIMIT) begin
              r_byte_idx    <= '0;
              r_word_idx    <= '0;
              r_idle_cnt    <= '0;
              r_timeout_err <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 32'd1;
            end
          end
        end
        HOLD: begin
          if (bus.rx_valid) begin
            r_overflow <= 1'b1;
          end
          if (bus.vec_ready) begin
            r_vec_valid   <= 1'b0;
            r_state       <= COLLECT;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bus.vec_data    = r_vec_data;
  assign bus.vec_valid   = r_vec_valid;
  assign bus.overflow    = r_overflow;
  assign bus.timeout_err = r_timeout_err;
  assign bus.frame_count = r_frame_count;
endmodule
